// File: rtl/ccom_sched.sv
// Sample-issue scheduler for channel compensation: takes one H estimate, then
// streams NSYM data symbols out of the symbol buffer against it.
module ccom_sched #(
  parameter int NFFT = 512,
  parameter int NSYM = 7,
  parameter int AW   = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          h_vld_in,
  input  logic          sym_rdy,
  input  logic          hold,
  output logic          h_vld_out,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          sp_vld_out,
  output logic [2:0]    sym_idx,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int BW = (NFFT > 1) ? $clog2(NFFT) : 1;
  localparam logic [BW-1:0] LAST_BIN = BW'(NFFT - 1);
  localparam logic [2:0]    LAST_SYM = 3'(NSYM - 1);

  typedef enum logic [2:0] {IDLE, LOAD_H, WAIT_SYM, RUN, FIN} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] bin;
  logic          h_beat;
  logic          last_bin;

  assign h_beat   = (state == LOAD_H) && h_vld_in;
  assign rd_en    = (state == RUN) && !hold;
  assign last_bin = (bin == LAST_BIN);
  assign busy     = (state != IDLE);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, matching the hardware it describes.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (start) state_nxt = LOAD_H;
      LOAD_H:   if (h_beat && last_bin) state_nxt = WAIT_SYM;
      WAIT_SYM: if (sym_rdy) state_nxt = RUN;
      RUN:      if (rd_en && last_bin) state_nxt = (sym_idx == LAST_SYM) ? FIN : WAIT_SYM;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin        <= '0;
      rd_addr    <= '0;
      sym_idx    <= '0;
      h_vld_out  <= 1'b0;
      sp_vld_out <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      h_vld_out  <= h_beat;
      sp_vld_out <= rd_en;
      done       <= (state == FIN);
      // H beats outside the load window are dropped and flagged until reset.
      if (h_vld_in && state != LOAD_H) err <= 1'b1;

      unique case (state)
        IDLE: if (start) begin
          bin     <= '0;
          rd_addr <= '0;
          sym_idx <= '0;
        end
        LOAD_H: if (h_beat) bin <= last_bin ? '0 : bin + 1'b1;
        RUN: if (rd_en) begin
          if (last_bin) begin
            bin <= '0;
            if (sym_idx == LAST_SYM) begin
              rd_addr <= '0;
              sym_idx <= '0;
            end else begin
              rd_addr <= rd_addr + 1'b1;
              sym_idx <= sym_idx + 1'b1;
            end
          end else begin
            bin     <= bin + 1'b1;
            rd_addr <= rd_addr + 1'b1;
          end
        end
        FIN: begin
          rd_addr <= '0;
          sym_idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccom_sched.sv
// Self-checking bench for ccom_sched: a counter-level frame model checked every
// cycle, directed frames for stall/starvation/error/reset, and random frames.
module tb_ccom_sched;

  localparam int NFFT  = 512;
  localparam int NSYM  = 7;
  localparam int AW    = 12;
  localparam int TOTAL = NFFT * NSYM;

  logic          clk = 1'b0;
  logic          rst, start, h_vld_in, sym_rdy, hold;
  logic          h_vld_out, rd_en, sp_vld_out, busy, done, err;
  logic [AW-1:0] rd_addr;
  logic [2:0]    sym_idx;

  ccom_sched #(.NFFT(NFFT), .NSYM(NSYM), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .h_vld_in(h_vld_in), .sym_rdy(sym_rdy),
    .hold(hold), .h_vld_out(h_vld_out), .rd_en(rd_en), .rd_addr(rd_addr),
    .sp_vld_out(sp_vld_out), .sym_idx(sym_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is "loading" until NFFT beats arrive, then samples are
  // issued in linear order; each NFFT-sample symbol needs one cycle of sym_rdy
  // seen while waiting before it may start.
  int cyc = 0;
  bit m_on, m_run, m_err, m_done, m_h, m_sp;
  int m_beats, m_iss;

  always @(posedge clk) begin : model
    bit idle, loading, waiting, fin, issuing;
    cyc++;
    idle    = !m_on;
    loading = m_on && m_beats < NFFT;
    waiting = m_on && m_beats == NFFT && !m_run && m_iss < TOTAL;
    fin     = m_on && m_iss == TOTAL;
    issuing = m_run && !hold;
    if (rst) begin
      m_on = 0; m_run = 0; m_beats = 0; m_iss = 0;
      m_err = 0; m_done = 0; m_h = 0; m_sp = 0;
    end else begin
      m_h    = loading && h_vld_in;
      m_sp   = issuing;
      m_done = fin;
      if (h_vld_in && !loading) m_err = 1;
      if (fin) m_on = 0;
      if (idle && start) begin
        m_on = 1; m_beats = 0; m_iss = 0; m_run = 0;
      end
      if (loading && h_vld_in) m_beats++;
      if (waiting && sym_rdy) m_run = 1;
      if (issuing) begin
        m_iss++;
        if (m_iss % NFFT == 0) m_run = 0;
      end
    end
  end

  bit cmp_en = 0;
  int h_cnt, sp_cnt, done_cnt, done_cyc, start_cyc;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", busy, m_on);
      check("rd_en", rd_en, m_run && !hold);
      check("rd_addr", rd_addr, (m_iss == TOTAL) ? 0 : m_iss);
      check("sym_idx", sym_idx, (m_iss == TOTAL) ? 0 : m_iss / NFFT);
      check("h_vld_out", h_vld_out, m_h);
      check("sp_vld_out", sp_vld_out, m_sp);
      check("done", done, m_done);
      check("err", err, m_err);
      if (h_vld_out)  h_cnt++;
      if (sp_vld_out) sp_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  bit rnd_en = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_en) begin
      hold    = ($urandom_range(0, 4) == 0);
      sym_rdy = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic begin_frame();
    h_cnt = 0; sp_cnt = 0; done_cnt = 0; done_cyc = -1;
    start_cyc = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_h(input bit gaps);
    int n = 0;
    while (n < NFFT) begin
      h_vld_in = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (h_vld_in) n++;
      tick();
    end
    h_vld_in = 1'b0;
  endtask

  task automatic wait_addr(input int a);
    int k = 0;
    while (!(rd_en && rd_addr == a) && k < 20000) begin
      tick();
      k++;
    end
    check("reach_addr_timeout", k < 20000, 1);
  endtask

  task automatic wait_done();
    int k = 0;
    while (done_cnt == 0 && k < 30000) begin
      tick();
      k++;
    end
    check("done_timeout", k < 30000, 1);
    repeat (3) tick();
    check("done_pulses", done_cnt, 1);
    check("h_vld_out_count", h_cnt, 512);
    check("sp_vld_out_count", sp_cnt, 3584);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; h_vld_in = 1'b0; sym_rdy = 1'b1; hold = 1'b0;
    tick();
    cmp_en = 1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_err", err, 0);
    tick();

    // Nominal frame.
    begin_frame();
    load_h(1'b0);
    wait_done();
    check("nominal_latency", done_cyc - start_cyc, 4105);
    check("nominal_err", err, 0);

    // Ten-cycle stall at address 700.
    begin_frame();
    load_h(1'b0);
    wait_addr(700);
    hold = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("stall_rd_en", rd_en, 0);
      check("stall_rd_addr", rd_addr, 700);
      tick();
    end
    hold = 1'b0;
    wait_done();
    check("stall_latency", done_cyc - start_cyc, 4115);

    // Symbol starvation after symbol 2.
    begin_frame();
    load_h(1'b0);
    wait_addr(1535);
    sym_rdy = 1'b0;
    repeat (50) tick();
    @(negedge clk);
    check("starve_busy", busy, 1);
    check("starve_rd_en", rd_en, 0);
    check("starve_sym_idx", sym_idx, 3);
    check("starve_rd_addr", rd_addr, 1536);
    tick();
    sym_rdy = 1'b1;
    tick();
    @(negedge clk);
    check("resume_rd_en", rd_en, 1);
    check("resume_rd_addr", rd_addr, 1536);
    wait_done();
    check("starve_latency", done_cyc - start_cyc, 4155);

    // Stray H beat while issuing samples.
    begin_frame();
    load_h(1'b0);
    wait_addr(1000);
    h_vld_in = 1'b1;
    tick();
    h_vld_in = 1'b0;
    wait_done();
    check("proterr_err_sticky", err, 1);
    check("proterr_latency", done_cyc - start_cyc, 4105);

    // Ignored start, then reset mid-frame, then a clean frame.
    begin_frame();
    load_h(1'b0);
    wait_addr(1200);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_addr(2000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_sym_idx", sym_idx, 0);
    check("rst_sp_vld_out", sp_vld_out, 0);
    check("rst_err", err, 0);
    tick();
    begin_frame();
    load_h(1'b0);
    wait_done();
    check("fresh_latency", done_cyc - start_cyc, 4105);
    check("fresh_err", err, 0);

    // Random H gaps, stalls and symbol availability.
    for (int f = 0; f < 2; f++) begin
      begin_frame();
      rnd_en = 1;
      load_h(1'b1);
      wait_done();
      rnd_en = 0;
      hold = 1'b0;
      sym_rdy = 1'b1;
      check("random_err", err, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ccom_sched.md
CCOM_SCHED -- requirements
Module: ccom_sched

Interface
REQ-001 Parameter NFFT, default 512, subcarriers per OFDM symbol (bins per H estimate).
REQ-002 Parameter NSYM, default 7, data symbols per frame compensated against one H estimate.
REQ-003 Parameter AW, default 12, symbol-buffer read-address width; NFFT*NSYM SHALL be <= 2^AW.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a frame.
REQ-007 h_vld_in  in  1  channel-estimate beat valid from CEST.
REQ-008 sym_rdy  in  1  level; the next data symbol is fully written in the SPFFT symbol buffer.
REQ-009 hold  in  1  level; downstream stall, pauses sample issue.
REQ-010 h_vld_out  out  1  drives CCOM din_H_vld.
REQ-011 rd_en  out  1  symbol-buffer read enable.
REQ-012 rd_addr  out  AW  symbol-buffer read address.
REQ-013 sp_vld_out  out  1  drives CCOM din_sp_vld; aligned with 1-cycle RAM read data.
REQ-014 sym_idx  out  3  index of the symbol being issued, 0..NSYM-1.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse at frame end.
REQ-017 err  out  1  sticky protocol-error flag.

Function
REQ-018 FSM states SHALL be IDLE, LOAD_H, WAIT_SYM, RUN, FIN.
REQ-019 IDLE: start=1 -> LOAD_H; bin count, rd_addr and sym_idx cleared to 0 on the same edge.
REQ-020 start outside IDLE SHALL be ignored, with no effect on state or err.
REQ-021 LOAD_H: h_vld_out SHALL equal h_vld_in registered one cycle; each beat increments the bin count.
REQ-022 LOAD_H: on the NFFT-th beat -> WAIT_SYM, with the bin count reset to 0.
REQ-023 h_vld_in=1 in any state other than LOAD_H SHALL set err and SHALL NOT be forwarded to h_vld_out.
REQ-024 WAIT_SYM: sym_rdy=1 -> RUN on the next edge; otherwise remain in WAIT_SYM (no timeout).
REQ-025 RUN: rd_en SHALL be combinational (state==RUN && !hold).
REQ-026 RUN: rd_addr and the bin count SHALL advance by 1 on each cycle with rd_en=1.
REQ-027 RUN: while hold=1, rd_addr, bin count and sym_idx SHALL hold their values.
REQ-028 rd_addr SHALL be the linear address sym_idx*NFFT + bin, with no reset between symbols.
REQ-029 RUN: on the issue of bin NFFT-1 with sym_idx<NSYM-1 -> sym_idx+1, bin=0, go to WAIT_SYM.
REQ-030 RUN: on the issue of bin NFFT-1 with sym_idx==NSYM-1 -> FIN.
REQ-031 sp_vld_out SHALL be rd_en registered one cycle, giving exactly NFFT*NSYM assertions per frame.
REQ-032 FIN: done=1 for exactly one cycle, rd_addr wraps to 0, sym_idx set to 0, -> IDLE.
REQ-033 Minimum frame latency with hold=0 and sym_rdy=1 SHALL be 1 + NFFT + NSYM*(1+NFFT) + 1 cycles from start to done.
REQ-034 The last sp_vld_out SHALL assert in the FIN cycle, before the done pulse is observed in IDLE.

Reset
REQ-035 rst=1 SHALL force IDLE on the next edge, including mid-frame.
REQ-036 rst=1 SHALL clear every output (h_vld_out, rd_en, rd_addr, sp_vld_out, sym_idx, busy, done, err) to 0 and clear all counters.
REQ-037 rst SHALL take priority over start, h_vld_in, sym_rdy and hold asserted in the same cycle.

Verification
REQ-038 Nominal frame: start, 512 H beats, sym_rdy=1, hold=0 -> 512 h_vld_out; 3584 sp_vld_out, rd_addr 0..3583 monotonic; done once at cycle 4105 after start; err=0.
REQ-039 Stall: hold=1 for 10 cycles at rd_addr=700 -> rd_en=0 and rd_addr=700 held; sp_vld_out total still 3584; done 10 cycles later than REQ-038.
REQ-040 Symbol starvation: sym_rdy=0 for 50 cycles after symbol 2 -> FSM in WAIT_SYM, sym_idx=3, rd_addr=1536 held; resumes one cycle after sym_rdy=1.
REQ-041 Protocol error: h_vld_in pulse during RUN -> err=1 sticky, h_vld_out stays 0, frame completes normally.
REQ-042 Ignored start / mid-frame reset: start during RUN -> no change; rst at rd_addr=2000 -> all outputs 0 next cycle, then a fresh start runs a full frame per REQ-038.
